// File: rtl/wb_arb_pkg.sv
// Shared types and limits for the Wishbone round-robin arbiter.
package wb_arb_pkg;

    localparam int MAX_MASTERS = 8;
    // Grant indices and the rotation pointer are sized for the largest supported config.
    localparam int IDX_W = $clog2(MAX_MASTERS);

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Wishbone bus bundle with grant; the arbiter is slave to each master and master to the shared bus.
interface wb_bus_t #(parameter int TAGSIZE = 1);

    logic                wb_cyc;
    logic                wb_stb;
    logic                wb_we;
    logic                wb_lock;
    logic [31:0]         wb_adr;
    logic [31:0]         wb_dat_ms;
    logic [3:0]          wb_sel;
    logic [TAGSIZE-1:0]  wb_tga;
    logic [TAGSIZE-1:0]  wb_tgd_ms;
    logic [31:0]         wb_dat_sm;
    logic [TAGSIZE-1:0]  wb_tgd_sm;
    logic                wb_ack;
    logic                wb_err;
    logic                wb_rty;
    logic                wb_gnt;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_lock, wb_adr, wb_dat_ms, wb_sel, wb_tga, wb_tgd_ms,
        input  wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty, wb_gnt
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_lock, wb_adr, wb_dat_ms, wb_sel, wb_tga, wb_tgd_ms,
        output wb_dat_sm, wb_tgd_sm, wb_ack, wb_err, wb_rty, wb_gnt
    );

endinterface

// File: rtl/wb_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
// Latency: combinational. Backpressure: none, pure function of its inputs.
module wb_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          vld
);

    int best;

    // The winner is the requester with the smallest forward distance from ptr.
    always_comb begin
        idx  = '0;
        vld  = 1'b0;
        best = N;
        for (int j = 0; j < N; j++) begin
            if (req[j] && (((j + N - int'(ptr)) % N) < best)) begin
                best = (j + N - int'(ptr)) % N;
                idx  = IW'(j);
                vld  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin Wishbone arbiter sharing one downstream bus among N_MASTERS masters.
// Latency: 1-cycle grant, zero-latency data/response routing. Backpressure: slave stalls pass through; watchdog errs a stuck strobe.
module wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int TAGSIZE   = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic     clk_i,
    input  logic     rstn_i,
    wb_bus_t.slave   wb_m [N_MASTERS],
    wb_bus_t.master  wb_s
);

    localparam int IW = IDX_W;
    localparam int CW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    arb_state_t      state;
    logic [IW-1:0]   gnt_idx;
    logic [IW-1:0]   rr_ptr;
    logic [CW-1:0]   wd_cnt;

    logic [N_MASTERS-1:0] m_cyc, m_stb, m_we, m_lock;
    logic [31:0]          m_adr    [N_MASTERS];
    logic [31:0]          m_dat    [N_MASTERS];
    logic [3:0]           m_sel    [N_MASTERS];
    logic [TAGSIZE-1:0]   m_tga    [N_MASTERS];
    logic [TAGSIZE-1:0]   m_tgd    [N_MASTERS];

    logic                 g_cyc, g_stb, g_we, g_lock;
    logic [31:0]          g_adr, g_dat;
    logic [3:0]           g_sel;
    logic [TAGSIZE-1:0]   g_tga, g_tgd;

    logic                 busy;
    logic                 wd_fire;
    logic                 wd_stall;
    logic [IW-1:0]        pick_idx;
    logic                 pick_vld;
    logic [IW-1:0]        next_ptr;
    logic                 unused_s_gnt;

    assign busy         = (state == ARB_BUSY);
    assign unused_s_gnt = wb_s.wb_gnt;

    genvar i;
    generate
        for (i = 0; i < N_MASTERS; i++) begin : g_port
            logic own;
            assign own        = busy && (gnt_idx == IW'(i));

            assign m_cyc[i]   = wb_m[i].wb_cyc;
            assign m_stb[i]   = wb_m[i].wb_stb;
            assign m_we[i]    = wb_m[i].wb_we;
            assign m_lock[i]  = wb_m[i].wb_lock;
            assign m_adr[i]   = wb_m[i].wb_adr;
            assign m_dat[i]   = wb_m[i].wb_dat_ms;
            assign m_sel[i]   = wb_m[i].wb_sel;
            assign m_tga[i]   = wb_m[i].wb_tga;
            assign m_tgd[i]   = wb_m[i].wb_tgd_ms;

            assign wb_m[i].wb_gnt    = own;
            assign wb_m[i].wb_ack    = own & wb_s.wb_ack;
            assign wb_m[i].wb_err    = own & (wb_s.wb_err | wd_fire);
            assign wb_m[i].wb_rty    = own & wb_s.wb_rty;
            assign wb_m[i].wb_dat_sm = own ? wb_s.wb_dat_sm : '0;
            assign wb_m[i].wb_tgd_sm = own ? wb_s.wb_tgd_sm : '0;
        end
    endgenerate

    always_comb begin
        g_cyc  = 1'b0;
        g_stb  = 1'b0;
        g_we   = 1'b0;
        g_lock = 1'b0;
        g_adr  = '0;
        g_dat  = '0;
        g_sel  = '0;
        g_tga  = '0;
        g_tgd  = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (gnt_idx == IW'(k)) begin
                g_cyc  = m_cyc[k];
                g_stb  = m_stb[k];
                g_we   = m_we[k];
                g_lock = m_lock[k];
                g_adr  = m_adr[k];
                g_dat  = m_dat[k];
                g_sel  = m_sel[k];
                g_tga  = m_tga[k];
                g_tgd  = m_tgd[k];
            end
        end
    end

    // The watchdog suppresses the strobe in its firing cycle so the slave never sees a late access.
    assign wd_fire  = (TIMEOUT != 0) && busy && (wd_cnt == CW'(TIMEOUT));
    assign wd_stall = g_cyc & g_stb & ~(wb_s.wb_ack | wb_s.wb_err | wb_s.wb_rty);

    assign wb_s.wb_cyc    = busy & g_cyc;
    assign wb_s.wb_stb    = busy & g_stb & ~wd_fire;
    assign wb_s.wb_we     = busy & g_we;
    assign wb_s.wb_lock   = busy & g_lock;
    assign wb_s.wb_adr    = busy ? g_adr : '0;
    assign wb_s.wb_dat_ms = busy ? g_dat : '0;
    assign wb_s.wb_sel    = busy ? g_sel : '0;
    assign wb_s.wb_tga    = busy ? g_tga : '0;
    assign wb_s.wb_tgd_ms = busy ? g_tgd : '0;

    assign next_ptr = (gnt_idx == IW'(N_MASTERS - 1)) ? '0 : gnt_idx + IW'(1);

    wb_rr_pick #(
        .N  (N_MASTERS),
        .IW (IW)
    ) u_pick (
        .req (m_cyc),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    // Release always passes through IDLE, so two owners are separated by one idle cycle.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state   <= ARB_IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            wd_cnt  <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    wd_cnt <= '0;
                    if (pick_vld) begin
                        state   <= ARB_BUSY;
                        gnt_idx <= pick_idx;
                    end
                end
                ARB_BUSY: begin
                    if (wd_fire || !wd_stall || (TIMEOUT == 0)) begin
                        wd_cnt <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CW'(1);
                    end
                    if (!g_cyc && !g_lock) begin
                        state  <= ARB_IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, multi-cycle corner sequences, randomized run vs. reference model.
module tb_wb_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic clk;
    logic rstn;

    logic [N-1:0] m_cyc, m_stb, m_we, m_lock;
    logic [31:0]  m_adr [N];
    logic [31:0]  m_dat [N];
    logic [3:0]   m_sel [N];
    logic [N-1:0] m_gnt, m_ack, m_err, m_rty;
    logic [31:0]  m_rdat [N];

    logic         s_ack, s_err, s_rty;
    logic [31:0]  s_dat;

    int checks;
    int errors;

    wb_bus_t #(.TAGSIZE(1)) m_bus [N] ();
    wb_bus_t #(.TAGSIZE(1)) s_bus ();

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_m
            assign m_bus[g].wb_cyc    = m_cyc[g];
            assign m_bus[g].wb_stb    = m_stb[g];
            assign m_bus[g].wb_we     = m_we[g];
            assign m_bus[g].wb_lock   = m_lock[g];
            assign m_bus[g].wb_adr    = m_adr[g];
            assign m_bus[g].wb_dat_ms = m_dat[g];
            assign m_bus[g].wb_sel    = m_sel[g];
            assign m_bus[g].wb_tga    = 1'b0;
            assign m_bus[g].wb_tgd_ms = 1'b0;
            assign m_gnt[g]  = m_bus[g].wb_gnt;
            assign m_ack[g]  = m_bus[g].wb_ack;
            assign m_err[g]  = m_bus[g].wb_err;
            assign m_rty[g]  = m_bus[g].wb_rty;
            assign m_rdat[g] = m_bus[g].wb_dat_sm;
        end
    endgenerate

    assign s_bus.wb_ack    = s_ack;
    assign s_bus.wb_err    = s_err;
    assign s_bus.wb_rty    = s_rty;
    assign s_bus.wb_dat_sm = s_dat;
    assign s_bus.wb_tgd_sm = 1'b0;
    assign s_bus.wb_gnt    = 1'b0;

    wb_arbiter #(
        .N_MASTERS (N),
        .TAGSIZE   (1),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .wb_m   (m_bus),
        .wb_s   (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stb;
        logic        we;
        logic [31:0] adr;
        logic        ack;
        logic        err;
        logic        rty;
        logic [31:0] sdat;
        logic        x_stb;
        logic [31:0] x_adr;
        logic [2:0]  x_resp;   // {ack, err, rty} seen by m0
        logic [31:0] x_rdat;
    } vec_t;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cyc = '0; m_stb = '0; m_we = '0; m_lock = '0;
        for (int i = 0; i < N; i++) begin
            m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0;
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;
    endtask

    // Reference model state: owner (-1 = nobody), rotation start, consecutive stall count.
    int owner;
    int start;
    int stall;
    logic dead;

    vec_t vt [7];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        rstn = 1'b0;

        vt[0] = '{1, 1, 32'h10, 1, 0, 0, 32'h1111, 1, 32'h10, 3'b100, 32'h1111};
        vt[1] = '{1, 1, 32'h14, 1, 0, 0, 32'h2222, 1, 32'h14, 3'b100, 32'h2222};
        vt[2] = '{1, 1, 32'h18, 1, 0, 0, 32'h3333, 1, 32'h18, 3'b100, 32'h3333};
        vt[3] = '{0, 0, 32'h18, 0, 0, 0, 32'h0,    0, 32'h18, 3'b000, 32'h0};
        vt[4] = '{1, 0, 32'h20, 0, 0, 0, 32'h4444, 1, 32'h20, 3'b000, 32'h4444};
        vt[5] = '{1, 0, 32'h20, 0, 1, 0, 32'h5555, 1, 32'h20, 3'b010, 32'h5555};
        vt[6] = '{1, 1, 32'h24, 0, 0, 1, 32'h6666, 1, 32'h24, 3'b001, 32'h6666};

        // Reset state
        @(negedge clk);
        chk("rst_s_cyc", 96'(s_bus.wb_cyc), 96'(0));
        chk("rst_gnt", 96'(m_gnt), 96'(0));
        #2 rstn = 1'b1;
        tick();

        // Simultaneous requests after reset: m0 first
        m_cyc = 2'b11;
        m_adr[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("arb_latency_gnt", 96'(m_gnt), 96'(2'b00));
        tick();
        @(negedge clk);
        chk("first_gnt_m0", 96'(m_gnt), 96'(2'b01));
        chk("first_s_cyc", 96'(s_bus.wb_cyc), 96'(1));
        tick();

        // Routing table with m0 granted, m1 also strobing and held off
        m_stb[1] = 1'b1;
        for (int v = 0; v < 7; v++) begin
            m_stb[0] = vt[v].stb; m_we[0] = vt[v].we; m_adr[0] = vt[v].adr;
            m_dat[0] = vt[v].adr + 32'h100;
            s_ack = vt[v].ack; s_err = vt[v].err; s_rty = vt[v].rty; s_dat = vt[v].sdat;
            @(negedge clk);
            chk($sformatf("vec%0d_s_cyc", v), 96'(s_bus.wb_cyc), 96'(1));
            chk($sformatf("vec%0d_s_stb", v), 96'(s_bus.wb_stb), 96'(vt[v].x_stb));
            chk($sformatf("vec%0d_s_adr", v), 96'(s_bus.wb_adr), 96'(vt[v].x_adr));
            chk($sformatf("vec%0d_s_dat", v), 96'(s_bus.wb_dat_ms), 96'(vt[v].x_adr + 32'h100));
            chk($sformatf("vec%0d_m0_resp", v), 96'({m_ack[0], m_err[0], m_rty[0]}), 96'(vt[v].x_resp));
            chk($sformatf("vec%0d_m0_rdat", v), 96'(m_rdat[0]), 96'(vt[v].x_rdat));
            chk($sformatf("vec%0d_m1_quiet", v), 96'({m_gnt[1], m_ack[1], m_err[1], m_rty[1], m_rdat[1]}), 96'(0));
            tick();
        end
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0; s_dat = '0;

        // m0 releases: one idle cycle, then m1
        m_cyc[0] = 1'b0; m_stb = '0;
        @(negedge clk);
        chk("release_still_m0", 96'(m_gnt), 96'(2'b01));
        chk("release_s_cyc", 96'(s_bus.wb_cyc), 96'(0));
        tick();
        @(negedge clk);
        chk("handover_idle", 96'(m_gnt), 96'(2'b00));
        tick();
        @(negedge clk);
        chk("handover_m1", 96'(m_gnt), 96'(2'b10));
        chk("handover_adr", 96'(s_bus.wb_adr), 96'(32'hDEAD_BEEF));
        tick();

        // Lock: m0 keeps the grant with cyc low while m1 requests
        m_cyc = 2'b01;
        @(negedge clk);
        tick();
        m_cyc = 2'b11;
        tick();
        @(negedge clk);
        chk("lock_setup_m0", 96'(m_gnt), 96'(2'b01));
        tick();
        m_lock[0] = 1'b1; m_cyc[0] = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("lock_hold%0d", c), 96'({m_gnt, s_bus.wb_cyc, s_bus.wb_lock}), 96'({2'b01, 1'b0, 1'b1}));
            tick();
        end
        m_lock[0] = 1'b0;
        tick();
        @(negedge clk);
        chk("unlock_idle", 96'(m_gnt), 96'(2'b00));
        tick();
        @(negedge clk);
        chk("unlock_m1", 96'(m_gnt), 96'(2'b10));
        tick();

        // Watchdog: silent slave, error on strobe cycles 9 and 18
        m_stb[1] = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            chk($sformatf("wd_c%0d", c), 96'({m_err[1], s_bus.wb_stb, m_gnt[1]}),
                96'({(c == 9 || c == 18), !(c == 9 || c == 18), 1'b1}));
            tick();
        end

        // Async reset mid-transfer, then both request: m0 wins
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_s_cyc", 96'({s_bus.wb_cyc, s_bus.wb_stb}), 96'(0));
        chk("async_rst_gnt", 96'({m_gnt, m_err}), 96'(0));
        m_cyc = 2'b11; m_stb = '0;
        @(negedge clk);
        #2 rstn = 1'b1;
        #1;
        chk("post_rst_no_gnt", 96'(m_gnt), 96'(2'b00));
        @(negedge clk);
        chk("post_rst_m0", 96'(m_gnt), 96'(2'b01));

        // Randomized run against the reference model
        rstn = 1'b0;
        idle_inputs();
        owner = -1; start = 0; stall = 0; dead = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        tick();
        for (int cyc_n = 0; cyc_n < 3000; cyc_n++) begin
            logic fire;
            logic resp;
            logic [31:0] x_s_adr;
            logic [1:0]  x_s_cs;
            logic [N-1:0] x_gnt, x_ack, x_err, x_rty;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) m_cyc[i] = ~m_cyc[i];
                m_stb[i]  = m_cyc[i] & 1'($urandom_range(0, 1));
                m_we[i]   = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 15) == 0) m_lock[i] = ~m_lock[i];
                m_adr[i]  = $urandom;
                m_dat[i]  = $urandom;
                m_sel[i]  = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 63) == 0) dead = ~dead;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            if (!dead) begin
                case ($urandom_range(0, 5))
                    0, 1:    s_ack = 1'b1;
                    2:       s_err = 1'b1;
                    3:       s_rty = 1'b1;
                    default: ;
                endcase
            end
            s_dat = $urandom;
            @(negedge clk);

            fire = (owner >= 0) && (stall == TO);
            resp = s_ack | s_err | s_rty;
            x_s_cs  = '0;
            x_s_adr = '0;
            x_gnt = '0; x_ack = '0; x_err = '0; x_rty = '0;
            if (owner >= 0) begin
                x_s_cs  = {m_cyc[owner], m_stb[owner] & ~fire};
                x_s_adr = m_adr[owner];
                x_gnt[owner] = 1'b1;
                x_ack[owner] = s_ack;
                x_err[owner] = s_err | fire;
                x_rty[owner] = s_rty;
            end
            chk("rnd_s_ctl", 96'({s_bus.wb_cyc, s_bus.wb_stb, s_bus.wb_adr}), 96'({x_s_cs, x_s_adr}));
            chk("rnd_m_resp", 96'({m_gnt, m_ack, m_err, m_rty}), 96'({x_gnt, x_ack, x_err, x_rty}));
            for (int i = 0; i < N; i++) begin
                chk($sformatf("rnd_m%0d_rdat", i), 96'(m_rdat[i]), 96'((i == owner) ? s_dat : 32'h0));
            end

            if (owner < 0) begin
                stall = 0;
                for (int k = 0; k < N; k++) begin
                    if (owner < 0 && m_cyc[(start + k) % N]) owner = (start + k) % N;
                end
            end else begin
                stall = (!fire && m_cyc[owner] && m_stb[owner] && !resp) ? stall + 1 : 0;
                if (!m_cyc[owner] && !m_lock[owner]) begin
                    start = (owner + 1) % N;
                    owner = -1;
                end
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter N_MASTERS, default 2, number of requesting masters (2..8).
REQ-002 Parameter TAGSIZE, default 1, tag width passed to every wb_bus_t instance.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles a strobe waits for ack/err/rty; 0 disables the watchdog.
REQ-004 clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 rstn_i  input  1  reset, asynchronous assert, active-low.
REQ-006 wb_m  wb_bus_t.slave [N_MASTERS]  array  master-facing ports; the arbiter acts as slave to each.
REQ-007 wb_s  wb_bus_t.master  1  shared downstream bus; the arbiter acts as master.

Function
REQ-008 FSM states SHALL be IDLE and BUSY, plus a registered grant index gnt_idx and a round-robin pointer rr_ptr.
REQ-009 IDLE: if any wb_m[i].wb_cyc=1, next state BUSY; gnt_idx = first requester searching from rr_ptr upward with wrap-around; arbitration latency is 1 cycle (cyc sampled at edge k, routing active from edge k).
REQ-010 IDLE: wb_s.wb_cyc, wb_stb, wb_we, wb_lock = 0; wb_adr, wb_dat_ms, wb_sel, tags = 0; all wb_m[i].wb_gnt, ack, err, rty = 0.
REQ-011 BUSY: wb_s outputs SHALL combinationally mirror wb_m[gnt_idx] outputs; wb_m[gnt_idx] receives wb_s ack/err/rty/dat_sm/tgd_sm and wb_gnt=1.
REQ-012 BUSY: non-granted masters see wb_gnt, ack, err, rty = 0 and wb_dat_sm, wb_tgd_sm = 0, regardless of their cyc/stb.
REQ-013 BUSY -> IDLE when wb_m[gnt_idx].wb_cyc=0 and wb_lock=0; on that transition rr_ptr = gnt_idx+1 modulo N_MASTERS.
REQ-014 While wb_m[gnt_idx].wb_lock=1, the grant SHALL be held even if that master's cyc=0.
REQ-015 Owner release and another master's request in the same cycle: one IDLE cycle always separates two owners.
REQ-016 Watchdog: 8-bit-or-wider counter increments each BUSY cycle with granted cyc&stb=1 and slave ack|err|rty=0; cleared on any response, on stb=0, and in IDLE.
REQ-017 When the counter equals TIMEOUT, the arbiter SHALL, for exactly that cycle, drive err=1 to the granted master, force wb_s.wb_stb=0, and clear the counter; grant is retained.
REQ-018 Slave ack/err/rty SHALL be forwarded with zero added latency; the arbiter adds no wait states inside a granted cycle.
REQ-019 If the granted master's cyc is 1 but stb is 0, wb_s.wb_cyc=1 and wb_s.wb_stb=0.

Reset
REQ-020 rstn_i=0 SHALL immediately force state=IDLE, gnt_idx=0, rr_ptr=0, watchdog=0, and all outputs to REQ-010 values, including mid-transfer.
REQ-021 After rstn_i deasserts, the first grant occurs no earlier than the first rising edge with rstn_i=1.

Structure
REQ-022 Package wb_arb_pkg SHALL hold the FSM state enum (ARB_IDLE, ARB_BUSY) and the maximum-masters constant.
REQ-023 Sub-module wb_rr_pick SHALL implement the combinational round-robin search (request vector, pointer -> index, valid); the arbiter instantiates exactly one.
REQ-024 Per-master output muxing stays in wb_arbiter; no extra pipeline registers on the data path.

Verification
REQ-025 N=2, m0 and m1 raise cyc in the same cycle after reset -> m0 granted first; after m0 drops cyc, 1 idle cycle, then m1 granted.
REQ-026 m0 issues 3 consecutive single writes (adr 0x10, 0x14, 0x18) under one cyc -> all appear on wb_s in order; m1 held with gnt=0 throughout.
REQ-027 m0 holds lock=1 and drops cyc for 4 cycles while m1 requests -> grant stays on m0 until lock=0.
REQ-028 TIMEOUT=8, slave never responds -> granted master gets err=1 on the 9th strobe cycle, wb_s.wb_stb=0 that cycle, counter restarts.
REQ-029 rstn_i pulsed low mid-transfer with m1 granted -> wb_s.wb_cyc=0 asynchronously; after release with both requesting, m0 granted.
